// File: rtl/neuron_mac_seq.sv
// Sequential multiply-accumulate neuron: bias + sum(data*weight) over several beats,
// then fixed-point shift, selectable activation and saturation to OUT_W.
module neuron_mac_seq #(
  parameter int DATA_W     = 16,
  parameter int WEIGHT_W   = 16,
  parameter int BIAS_W     = 32,
  parameter int N_INPUTS   = 4,
  parameter int LANES      = 2,
  parameter int ACC_W      = 40,
  parameter int OUT_W      = 24,
  parameter int FRAC_SHIFT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [1:0]                 act_mode,
  input  logic signed [BIAS_W-1:0]   bias,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*DATA_W-1:0]    in_data,
  input  logic [LANES*WEIGHT_W-1:0]  in_weight,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [OUT_W-1:0]    out_data,
  output logic                       sat_flag,
  output logic                       busy
);

  localparam int unsigned BEATS  = N_INPUTS / LANES;
  localparam int          CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int          PROD_W = DATA_W + WEIGHT_W;

  // Saturation bounds of the OUT_W result, expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] OMAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OMIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, ACT, OUT} state_t;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         beat_q, beat_d;
  logic [1:0]               mode_q, mode_d;
  logic signed [OUT_W-1:0]  out_data_q, out_data_d;
  logic                     sat_q, sat_d;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  lane_sum;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [ACC_W-1:0]  activated;

  always_comb begin
    prod     = '0;
    lane_sum = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      prod     = $signed(in_data[l*DATA_W +: DATA_W]) * $signed(in_weight[l*WEIGHT_W +: WEIGHT_W]);
      lane_sum = lane_sum + ACC_W'(prod);
    end
  end

  always_comb begin
    shifted = acc_q >>> FRAC_SHIFT;
    case (mode_q)
      2'd1:    activated = (shifted > 0) ? shifted : '0;
      2'd2:    activated = (shifted >= 0) ? shifted : (shifted >>> 3);
      default: activated = shifted;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    beat_d     = beat_q;
    mode_d     = mode_q;
    out_data_d = out_data_q;
    sat_d      = sat_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = act_mode;
          acc_d   = ACC_W'(bias);
          beat_d  = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d = acc_q + lane_sum;
          if (beat_q == CNT_W'(BEATS - 1)) begin
            state_d = ACT;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      ACT: begin
        if (activated > OMAX) begin
          out_data_d = OMAX[OUT_W-1:0];
          sat_d      = 1'b1;
        end else if (activated < OMIN) begin
          out_data_d = OMIN[OUT_W-1:0];
          sat_d      = 1'b1;
        end else begin
          out_data_d = activated[OUT_W-1:0];
          sat_d      = 1'b0;
        end
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      beat_q     <= '0;
      mode_q     <= '0;
      out_data_q <= '0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      beat_q     <= beat_d;
      mode_q     <= mode_d;
      out_data_q <= out_data_d;
      sat_q      <= sat_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign out_data  = out_data_q;
  assign sat_flag  = sat_q;

endmodule
